// File: rtl/rsa_host_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rsa_host_ctrl: ARM command decoder, operand slot bank and sequencer    |
// | for the Montgomery exponentiation core. Optional: RSA_CYCLE_COUNT_EN.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module rsa_host_ctrl #(
  parameter int DATA_W  = 1024,
  parameter int N_SLOTS = 5
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [31:0]               cmd,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  output logic                      done,
  input  logic                      done_read,
  output logic                      err,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic [DATA_W-1:0]         din,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [DATA_W-1:0]         dout,
  output logic                      core_resetn,
  output logic                      core_start,
  output logic                      core_mode,
  output logic [N_SLOTS*DATA_W-1:0] core_params,
  input  logic [DATA_W-1:0]         core_result,
  input  logic                      core_done,
  output logic [3:0]                status
);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_load  = 3'd1;
  localparam logic [2:0] c_start = 3'd2;
  localparam logic [2:0] c_busy  = 3'd3;
  localparam logic [2:0] c_send  = 3'd4;
  localparam logic [2:0] c_done  = 3'd5;

  localparam logic [3:0] c_op_load    = 4'd0;
  localparam logic [3:0] c_op_encrypt = 4'd1;
  localparam logic [3:0] c_op_read    = 4'd2;
  localparam logic [3:0] c_op_decrypt = 4'd3;
  localparam logic [3:0] c_op_abort   = 4'd4;
`ifdef RSA_CYCLE_COUNT_EN
  localparam logic [3:0] c_op_cycles  = 4'd5;
`endif
  localparam logic [4:0] c_n_slots    = 5'(N_SLOTS);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic              r_active;
  logic [3:0]        r_idx;
  logic              r_mode;
  logic [DATA_W-1:0] r_result;
  logic              r_result_valid;
  logic              r_err;
  logic              r_err_sticky;
  logic              w_idle_err;
`ifdef RSA_CYCLE_COUNT_EN
  logic              r_send_cnt;
  logic [31:0]       r_cycles;
`endif

  logic [3:0] w_op;
  logic [3:0] w_idx;
  logic       w_idx_ok;
  logic       w_cmd_acc;
  logic       w_unused_cmd;

  assign w_op         = cmd[3:0];
  assign w_idx        = cmd[11:8];
  assign w_idx_ok     = {1'b0, w_idx} < c_n_slots;
  assign w_cmd_acc    = cmd_valid & cmd_ready;
  assign w_unused_cmd = ^{cmd[31:12], cmd[7:4]};

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= c_idle;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idle_err  = 1'b0;
    case (r_state)
      c_idle: begin
        if (w_cmd_acc) begin
          case (w_op)
            c_op_load: begin
              if (w_idx_ok) w_state_nxt = c_load;
              else begin
                w_state_nxt = c_done;
                w_idle_err  = 1'b1;
              end
            end
            c_op_encrypt, c_op_decrypt: w_state_nxt = c_start;
            c_op_read: begin
              if (r_result_valid) w_state_nxt = c_send;
              else begin
                w_state_nxt = c_done;
                w_idle_err  = 1'b1;
              end
            end
`ifdef RSA_CYCLE_COUNT_EN
            c_op_cycles: w_state_nxt = c_send;
`endif
            // ABORT with nothing running is reported as an error too
            default: begin
              w_state_nxt = c_done;
              w_idle_err  = 1'b1;
            end
          endcase
        end
      end
      c_load:  if (din_valid) w_state_nxt = c_done;
      c_start: w_state_nxt = c_busy;
      c_busy:  if (core_done || (w_cmd_acc && w_op == c_op_abort)) w_state_nxt = c_done;
      c_send:  if (dout_ready) w_state_nxt = c_done;
      c_done:  if (done_read) w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    cmd_ready   = 1'b0;
    din_ready   = 1'b0;
    dout_valid  = 1'b0;
    done        = 1'b0;
    core_resetn = 1'b0;
    core_start  = 1'b0;
    case (r_state)
      // r_active keeps cmd_ready low in the cycle(s) that reset is applied
      c_idle:  cmd_ready = r_active;
      c_load:  din_ready = 1'b1;
      c_start: begin
        core_resetn = 1'b1;
        core_start  = 1'b1;
      end
      c_busy: begin
        core_resetn = 1'b1;
        cmd_ready   = 1'b1;
      end
      c_send:  dout_valid = 1'b1;
      c_done:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_active       <= 1'b0;
      r_idx          <= '0;
      r_mode         <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
      r_err_sticky   <= 1'b0;
`ifdef RSA_CYCLE_COUNT_EN
      r_send_cnt     <= 1'b0;
      r_cycles       <= '0;
`endif
    end else begin
      r_active <= 1'b1;
      case (r_state)
        c_idle: begin
          if (w_cmd_acc) begin
            r_idx <= w_idx;
            if (w_op == c_op_encrypt || w_op == c_op_decrypt)
              r_mode <= (w_op == c_op_decrypt);
`ifdef RSA_CYCLE_COUNT_EN
            r_send_cnt <= (w_op == c_op_cycles);
`endif
            if (w_idle_err) begin
              r_err        <= 1'b1;
              r_err_sticky <= 1'b1;
            end
          end
        end
        c_start: begin
          r_result_valid <= 1'b0;
`ifdef RSA_CYCLE_COUNT_EN
          r_cycles       <= '0;
`endif
        end
        c_busy: begin
`ifdef RSA_CYCLE_COUNT_EN
          if (r_cycles != '1) r_cycles <= r_cycles + 32'd1;
`endif
          if (core_done) begin
            r_result       <= core_result;
            r_result_valid <= 1'b1;
          end
          if (w_cmd_acc && w_op != c_op_abort) begin
            r_err        <= 1'b1;
            r_err_sticky <= 1'b1;
          end
        end
        c_done: if (done_read) r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
    logic [DATA_W-1:0] r_slot;
    always_ff @(posedge clk) begin
      if (!resetn)
        r_slot <= '0;
      else if (r_state == c_load && din_valid && r_idx == 4'(k))
        r_slot <= din;
    end
    assign core_params[k*DATA_W +: DATA_W] = r_slot;
  end

`ifdef RSA_CYCLE_COUNT_EN
  assign dout = r_send_cnt ? {{(DATA_W-32){1'b0}}, r_cycles} : r_result;
`else
  assign dout = r_result;
`endif
  assign err       = r_err;
  assign core_mode = r_mode;
  assign status    = {r_err_sticky, r_state};

endmodule
`default_nettype wire
